excess3_encoder: RTL and testbench

Multi-digit BCD-to-Excess-3 encoder. It is the encoding counterpart of the combinational Excess-3-to-BCD subtract-3 stage already in the datapath. It accepts a packed BCD word over a valid/ready handshake and converts one digit per clock, least-significant digit first, by adding 3. It then presents the Excess-3 word, plus a sticky invalid-digit flag, on a second valid/ready handshake toward the Excess-3 consumers.

---
 rtl/excess3_encoder.sv | 124 ++++++++++++
 tb/tb_excess3_encoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/excess3_encoder.sv
// excess3_encoder
// Multi-digit BCD to Excess-3 encoder. A packed BCD word is accepted over a
// valid/ready handshake, converted one digit per clock (least-significant
// digit first) by adding 3, and then held on an output valid/ready handshake
// together with a sticky flag marking any input digit above 9.
module excess3_encoder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_xs3,
  output logic                  out_err
);

  localparam int W    = 4 * DIGITS;
  // Keep the index at least one bit wide so DIGITS=1 still elaborates.
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [W-1:0]      src_reg,   src_next;
  logic [W-1:0]      res_reg,   res_next;
  logic              err_reg,   err_next;
  logic [IDXW-1:0]   idx_reg,   idx_next;

  // Per-digit converted value and invalid marker, computed for every source
  // digit; the FSM picks the one selected by idx each CONV cycle.
  logic [3:0]        digit_xs3 [DIGITS];
  logic [DIGITS-1:0] digit_bad;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      // Add 3 to a legal digit; an illegal digit maps to the unused code 0000.
      always_comb begin
        digit_bad[gi] = (src_reg[4*gi +: 4] > 4'd9);
        digit_xs3[gi] = digit_bad[gi] ? 4'b0000 : (src_reg[4*gi +: 4] + 4'd3);
      end
    end
  endgenerate

  // State and datapath registers; reset returns everything to an empty IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      src_reg   <= '0;
      res_reg   <= '0;
      err_reg   <= 1'b0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      res_reg   <= res_next;
      err_reg   <= err_next;
      idx_reg   <= idx_next;
    end
  end

  // Next-state and datapath update: accept in IDLE, one digit per CONV edge,
  // wait for the consumer in HOLD.
  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    res_next   = res_reg;
    err_next   = err_reg;
    idx_next   = idx_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          src_next   = in_bcd;
          res_next   = '0;
          err_next   = 1'b0;
          idx_next   = '0;
          state_next = CONV;
        end
      end

      CONV: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_reg == IDXW'(i)) begin
            res_next[4*i +: 4] = digit_xs3[i];
            if (digit_bad[i]) begin
              err_next = 1'b1;
            end
          end
        end
        idx_next = idx_reg + IDXW'(1);
        if (idx_reg == LAST_IDX) begin
          state_next = HOLD;
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake outputs depend on state only; the result registers drive data.
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == HOLD);
    out_xs3   = res_reg;
    out_err   = err_reg;
  end

endmodule

// File: tb/tb_excess3_encoder.sv
module tb_excess3_encoder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_bcd;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_xs3;
  logic          out_err;

  int errors;
  int checks;

  excess3_encoder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_xs3   (out_xs3),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: each decimal digit plus three, illegal digits give 0 and set err.
  task automatic model(input logic [W-1:0] bcd, output logic [W-1:0] xs3, output logic err);
    int d;
    int acc;
    acc = 0;
    err = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = (int'(bcd) / (16 ** i)) % 16;
      if (d > 9) begin
        err = 1'b1;
        acc = acc * 16;
      end else begin
        acc = acc * 16 + (d + 3);
      end
    end
    xs3 = W'(acc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input logic [W-1:0] bcd, input int stall);
    logic [W-1:0] exp_x;
    logic         exp_e;
    int           n;
    model(bcd, exp_x, exp_e);
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_bcd   = bcd;
    tick();
    in_valid = 1'b0;
    in_bcd   = W'($urandom);
    check("busy_ready", 32'(in_ready), 32'd0);
    for (int k = 1; k < DIGITS; k++) begin
      tick();
      check("early_valid", 32'(out_valid), 32'd0);
    end
    tick();
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_xs3", 32'(out_xs3), 32'(exp_x));
    check("out_err", 32'(out_err), 32'(exp_e));
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom);
      in_bcd    = W'($urandom);
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_xs3", 32'(out_xs3), 32'(exp_x));
      check("hold_err", 32'(out_err), 32'(exp_e));
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_xs3", 32'(out_xs3), 32'(exp_x));
    check("idle_err", 32'(out_err), 32'(exp_e));
    $display("word bcd=%h xs3=%h err=%b stall=%0d", bcd, out_xs3, out_err, stall);
  endtask

  initial begin
    logic [W-1:0] w;
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bcd    = '0;
    out_ready = 1'b0;

    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_xs3", 32'(out_xs3), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed words
    run_word(16'h1234, 0);
    run_word(16'h0000, 0);
    run_word(16'h9999, 0);
    run_word(16'h12A4, 0);
    run_word(16'h0001, 0);
    run_word(16'h5678, 10);

    // Throughput with in_valid and out_ready held high
    in_valid  = 1'b1;
    in_bcd    = 16'h0123;
    out_ready = 1'b1;
    tick();                       // edge 0: accept
    in_bcd = 16'h4567;
    check("tp_busy", 32'(in_ready), 32'd0);
    repeat (4) tick();            // edges 1..4
    check("tp_valid1", 32'(out_valid), 32'd1);
    check("tp_xs3_1", 32'(out_xs3), 32'h3456);
    tick();                       // edge 5: back to IDLE
    check("tp_idle", 32'(in_ready), 32'd1);
    tick();                       // edge 6: second accept
    check("tp_accept2", 32'(in_ready), 32'd0);
    repeat (4) tick();            // edges 7..10
    check("tp_valid2", 32'(out_valid), 32'd1);
    check("tp_xs3_2", 32'(out_xs3), 32'h789A);
    check("tp_err_2", 32'(out_err), 32'd0);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("tp_end_ready", 32'(in_ready), 32'd1);
    $display("throughput words 0123 4567 done");

    // Asynchronous reset in the middle of a conversion
    in_valid = 1'b1;
    in_bcd   = 16'h1234;
    tick();                       // edge 0: accept
    in_valid = 1'b0;
    tick();                       // edge 1
    @(posedge clk);               // edge 2
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_xs3", 32'(out_xs3), 32'd0);
    check("mid_rst_err", 32'(out_err), 32'd0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset mid-conversion done");
    run_word(16'h0008, 0);

    // Randomized words: mix of all-legal and arbitrary nibbles
    for (int t = 0; t < 24; t++) begin
      if (t % 2 == 0) begin
        w = '0;
        for (int i = 0; i < DIGITS; i++) begin
          w[4*i +: 4] = 4'($urandom_range(9, 0));
        end
      end else begin
        w = W'($urandom);
      end
      run_word(w, int'($urandom_range(3, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
